// File: rtl/rle_pkg.sv
// rle_pkg: shared run-length codec types and mode helpers for rle_enc/rle_dec
package rle_pkg;
  localparam int DW = 32;
  localparam int CNT_W = 31;
  typedef enum logic [1:0] {RLE_8, RLE_16, RLE_24, RLE_32} rle_mode_t;
  typedef enum logic {IDLE, REPEAT} rle_dec_state_t;
  function automatic logic [4:0] rle_flag_pos(input logic [1:0] mode);
    return {mode, 3'b111};
  endfunction
  function automatic logic [DW-1:0] rle_width_mask(input logic [1:0] mode);
    return {DW{1'b1}} >> {~mode, 3'b000};
  endfunction
endpackage

// File: rtl/rle_dec_outreg.sv
// rle_dec_outreg: single valid/ready output register that holds its contents while stalled
module rle_dec_outreg
  import rle_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic          i_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data
);
  logic          r_valid;
  logic [DW-1:0] r_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end
  assign o_valid = r_valid;
  assign o_data  = r_data;
endmodule

// File: rtl/rle_dec.sv
// rle_dec: run-length decoder expanding value/count words into one sample per cycle
// RLE_DEC_STATS_EN adds sample_count and err_count statistics outputs
module rle_dec
  import rle_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    mode,
  input  logic          rle_repeat_mode,
  input  logic [DW-1:0] dataIn,
  input  logic          validIn,
  output logic          readyIn,
  output logic [DW-1:0] dataOut,
  output logic          validOut,
  input  logic          readyOut,
  output logic          rle_err
`ifdef RLE_DEC_STATS_EN
  ,
  output logic [31:0]   sample_count,
  output logic [7:0]    err_count
`endif
);
  rle_dec_state_t   r_state, w_state_nxt;
  logic [CNT_W-1:0] r_rep_cnt, w_rep_cnt_nxt, w_cnt, w_n;
  logic [DW-1:0]    r_last_val, w_mask, w_val, w_load_data;
  logic             r_have_val, r_err;
  logic             w_flag, w_acc, w_val_acc, w_rep_start, w_rep_xfer, w_last, w_load;
  always_comb begin
    w_mask        = rle_width_mask(mode);
    w_flag        = dataIn[rle_flag_pos(mode)];
    w_val         = dataIn & w_mask;
    w_cnt         = dataIn[CNT_W-1:0] & w_mask[DW-1:1];
    w_n           = (w_cnt > CNT_W'(rle_repeat_mode)) ? w_cnt - CNT_W'(rle_repeat_mode) : '0;
    w_rep_xfer    = (r_state == REPEAT) & readyOut;
    w_last        = w_rep_xfer & (r_rep_cnt == CNT_W'(1));
    readyIn       = ~reset & ((r_state == IDLE) ? (~validOut | readyOut) : w_last);
    w_acc         = validIn & readyIn;
    w_val_acc     = w_acc & ~w_flag;
    w_rep_start   = w_acc & w_flag & r_have_val & (|w_n);
    // a count word loads the first repeat immediately so the stream has no bubble
    w_load        = w_val_acc | w_rep_start | (w_rep_xfer & (r_rep_cnt > CNT_W'(1)));
    w_load_data   = w_val_acc ? w_val : r_last_val;
    w_state_nxt   = w_rep_start ? REPEAT : (w_last ? IDLE : r_state);
    w_rep_cnt_nxt = w_rep_start ? w_n : (w_rep_xfer ? r_rep_cnt - CNT_W'(1) : r_rep_cnt);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rep_cnt  <= '0;
      r_last_val <= '0;
      r_have_val <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rep_cnt  <= w_rep_cnt_nxt;
      r_err      <= w_acc & w_flag & ~r_have_val;
      if (w_val_acc) begin
        r_last_val <= w_val;
        r_have_val <= 1'b1;
      end
    end
  end
  rle_dec_outreg u_outreg (
    .clk     (clock),
    .rst     (reset),
    .i_load  (w_load),
    .i_data  (w_load_data),
    .i_ready (readyOut),
    .o_valid (validOut),
    .o_data  (dataOut)
  );
  assign rle_err = r_err;
`ifdef RLE_DEC_STATS_EN
  logic [31:0] r_sample_count;
  logic [7:0]  r_err_count;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sample_count <= '0;
      r_err_count    <= '0;
    end else begin
      if (validOut & readyOut) r_sample_count <= r_sample_count + 32'd1;
      if (r_err & (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
    end
  end
  assign sample_count = r_sample_count;
  assign err_count    = r_err_count;
`endif
endmodule
